mult_accum: RTL and testbench
=============================

Name: mult_accum

Overview:
- Signed accumulator stage that sits directly downstream of the mult block and consumes its signed 64-bit product Z.
- Sums a group of products into a wider accumulator, using a valid/ready handshake on both input and output.
- The end of a group is marked by in_last. The group total, beat count and overflow flag are then presented on a registered output until the consumer takes them.

Parameters:
- W, 64, width of the incoming signed product.
- ACC_W, 72, accumulator and output width; must be >= W.
- CNT_W, 16, beat-counter width.
- SATURATE, 0, overflow handling: 0 = two's-complement wrap, 1 = clamp to the signed ACC_W max/min.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  discard the partial group in progress.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  W  signed product (mult Z).
- in_last  input  1  this beat closes the group.
- out_valid  output  1  out_* fields hold a completed group.
- out_ready  input  1  consumer takes the result.
- out_data  output  ACC_W  signed group sum.
- out_count  output  CNT_W  number of beats in the group.
- out_ovf  output  1  overflow occurred at least once in the group.

Behaviour:
- Reset, synchronous, checked first every cycle:
  - state=ACCUM; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_data=0, out_count=0, out_ovf=0.
  - Reset mid-group or mid-HOLD drops everything; the next cycle after rst deasserts has in_ready=1.
- States: ACCUM and HOLD.
  - in_ready = (state==ACCUM). It is a combinational decode of the state register only and never depends on in_valid.
  - Beat = in_valid & in_ready.
- ACCUM, on a beat:
  - sum = acc + sign_extend(in_data, ACC_W).
  - Overflow = both operands have the same sign and sum's sign differs from them.
  - If overflow: ovf_next=1. With SATURATE=1, sum is clamped to 2^(ACC_W-1)-1 (positive operands) or -2^(ACC_W-1) (negative operands). With SATURATE=0, the wrapped sum is kept.
  - cnt_next = cnt+1, saturating at all-ones; a saturated count does not set ovf.
- ACCUM, beat with in_last=0: acc<=sum, cnt<=cnt_next, ovf<=ovf_next.
- ACCUM, beat with in_last=1:
  - out_data<=sum, out_count<=cnt_next, out_ovf<=ovf_next, out_valid<=1.
  - acc, cnt and ovf are cleared to 0; state<=HOLD.
  - Latency from the last beat to out_valid is 1 cycle.
- HOLD:
  - out_* are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid<=0 and state<=ACCUM, so in_ready=1 in the next cycle.
  - There is no bypass: at most one result every 2 cycles for single-beat groups.
- clear:
  - In ACCUM with no beat: acc=0, cnt=0, ovf=0.
  - In ACCUM with a simultaneous beat: the beat starts a fresh group, so sum=sign_extend(in_data), cnt_next=1, ovf_next=0. in_last is honoured on that beat.
  - In HOLD: clear is ignored and the pending result is not affected.
- out_data/out_count/out_ovf keep their last values after the handshake; they are only meaningful while out_valid=1.
- in_data is never sampled when in_ready=0; upstream must hold the beat.

Test Plan:
- Reset + single group: in_data=5, -3, 10 with in_last on the third beat, out_ready=1 → out_valid 1 cycle after the third beat; out_data=12, out_count=3, out_ovf=0; in_ready=1 two cycles after the third beat.
- Backpressure: group {7} with in_last=1, out_ready=0 for 4 cycles → out_data=7 held stable, in_ready=0 for all 4 cycles, in_valid ignored; out_ready=1 → handshake, then in_ready=1 next cycle.
- Overflow with ACC_W=W=64, in_data=0x7FFF_FFFF_FFFF_FFFF then 1 (last):
  - SATURATE=0 → out_data=0x8000_0000_0000_0000, out_ovf=1.
  - SATURATE=1 → out_data=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
  - A following group {1} (last) → out_ovf=0.
- Clear collisions:
  - Beats 100, 200, then clear with no beat, then 9 (last) → out_data=9, out_count=1.
  - clear together with beat -4 (last) → out_data=-4, out_count=1.
  - clear while in HOLD → out_data unchanged.
- Reset mid-group: beats 1, 2, assert rst 1 cycle, then 3 (last) → out_data=3, out_count=1; reset during HOLD → out_valid=0 next cycle.
- Random vs model: 1000 beats of random 64-bit signed data, random in_last/out_ready/clear → every output matches a reference model of sums, counts and ovf, with no lost or duplicated groups.

Source files
------------

// File: rtl/mult_accum.sv
// Signed group accumulator behind the mult block: sums Z products until in_last,
// then holds the registered total, beat count and overflow flag until taken.
module mult_accum #(
  parameter int W        = 64,
  parameter int ACC_W    = 72,
  parameter int CNT_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [0:0]              state;
  logic signed [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic                    ovf_p0;

  logic signed [ACC_W-1:0] acc_base;
  logic [CNT_W-1:0]        cnt_base;
  logic                    ovf_base;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] raw;
  logic                    ovf_hit;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt_next;
  logic                    ovf_next;
  logic                    beat;

  // Clamp on overflow only when saturation is enabled; the operand sign picks the rail.
  function automatic logic signed [ACC_W-1:0] sat_sum(
    input logic signed [ACC_W-1:0] val,
    input logic                    ovf,
    input logic                    neg
  );
    logic signed [ACC_W-1:0] res;
    res = val;
    if ((SATURATE != 0) && ovf) res = neg ? ACC_MIN : ACC_MAX;
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign in_ready = (state == ACCUM);
  assign beat     = in_valid & in_ready;

  // A clear coinciding with a beat makes that beat the first of a fresh group.
  always_comb begin
    acc_base = clear ? '0 : acc_p0;
    cnt_base = clear ? '0 : cnt_p0;
    ovf_base = clear ? 1'b0 : ovf_p0;
    ext      = ACC_W'(in_data);
    raw      = acc_base + ext;
    ovf_hit  = (acc_base[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc_base[ACC_W-1]);
    sum      = sat_sum(raw, ovf_hit, ext[ACC_W-1]);
    cnt_next = cnt_inc(cnt_base);
    ovf_next = ovf_base | ovf_hit;
  end

  // Stage p0: running accumulator and the held output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc_p0    <= '0;
      cnt_p0    <= '0;
      ovf_p0    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (beat) begin
            if (in_last) begin
              out_data  <= sum;
              out_count <= cnt_next;
              out_ovf   <= ovf_next;
              out_valid <= 1'b1;
              acc_p0    <= '0;
              cnt_p0    <= '0;
              ovf_p0    <= 1'b0;
              state     <= HOLD;
            end else begin
              acc_p0 <= sum;
              cnt_p0 <= cnt_next;
              ovf_p0 <= ovf_next;
            end
          end else if (clear) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
            ovf_p0 <= 1'b0;
          end
        end
        default: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_accum.sv
// Directed and randomized checks of mult_accum in wrap and saturate modes (ACC_W = W = 64).
module tb_mult_accum;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_last, out_ready;
  logic signed [63:0] in_data;
  logic        rdy_w, rdy_s, vld_w, vld_s, ovf_w, ovf_s;
  logic signed [63:0] dat_w, dat_s;
  logic [15:0] cnt_w, cnt_s;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  mult_accum #(.W(64), .ACC_W(64), .CNT_W(16), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_w),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_w), .out_ready(out_ready),
    .out_data(dat_w), .out_count(cnt_w), .out_ovf(ovf_w)
  );

  mult_accum #(.W(64), .ACC_W(64), .CNT_W(16), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_s),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_s), .out_ready(out_ready),
    .out_data(dat_s), .out_count(cnt_s), .out_ovf(ovf_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Check both instances when their results must agree.
  task automatic chk_out(input string tag, input logic [63:0] d, input logic [15:0] c, input logic o);
    chk({tag, ".vld_w"}, 64'(vld_w), 64'd1);
    chk({tag, ".dat_w"}, dat_w, d);
    chk({tag, ".cnt_w"}, 64'(cnt_w), 64'(c));
    chk({tag, ".ovf_w"}, 64'(ovf_w), 64'(o));
    chk({tag, ".dat_s"}, dat_s, d);
    chk({tag, ".cnt_s"}, 64'(cnt_s), 64'(c));
  endtask

  // Reference state for the random phase
  logic        m_hold;
  logic [63:0] m_acc_w, m_acc_s, e_w, e_s;
  logic [15:0] m_cnt, e_cnt;
  logic        m_ovf_w, m_ovf_s, e_ovf_w, e_ovf_s;

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; in_data = '0;
    tick();
    rst = 1'b0;
    chk("rst.vld", 64'(vld_w), 64'd0);
    chk("rst.rdy", 64'(rdy_w), 64'd1);
    chk("rst.dat", dat_w, 64'd0);
    chk("rst.cnt", 64'(cnt_w), 64'd0);

    // Single group 5 - 3 + 10
    beat(64'sd5, 1'b0);
    beat(-64'sd3, 1'b0);
    beat(64'sd10, 1'b1);
    chk_out("grp", 64'sd12, 16'd3, 1'b0);
    chk("grp.rdy", 64'(rdy_w), 64'd0);
    tick();
    chk("grp.vld_after", 64'(vld_w), 64'd0);
    chk("grp.rdy_after", 64'(rdy_w), 64'd1);

    // Backpressure: result held, input ignored
    out_ready = 1'b0;
    beat(64'sd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 64'sd99; in_last = 1'b1;
      tick();
      chk("bp.dat", dat_w, 64'sd7);
      chk("bp.rdy", 64'(rdy_w), 64'd0);
      chk("bp.vld", 64'(vld_w), 64'd1);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp.vld_after", 64'(vld_w), 64'd0);
    chk("bp.rdy_after", 64'(rdy_w), 64'd1);
    chk("bp.dat_keep", dat_w, 64'sd7);

    // Overflow: wrap vs saturate
    beat(MAX64, 1'b0);
    beat(64'sd1, 1'b1);
    chk("ovf.dat_w", dat_w, MIN64);
    chk("ovf.ovf_w", 64'(ovf_w), 64'd1);
    chk("ovf.dat_s", dat_s, MAX64);
    chk("ovf.ovf_s", 64'(ovf_s), 64'd1);
    chk("ovf.cnt_s", 64'(cnt_s), 64'd2);
    tick();
    beat(64'sd1, 1'b1);
    chk_out("ovf.next", 64'sd1, 16'd1, 1'b0);
    chk("ovf.next.ovf_s", 64'(ovf_s), 64'd0);
    tick();

    // Negative saturation
    beat(MIN64, 1'b0);
    beat(-64'sd1, 1'b1);
    chk("novf.dat_w", dat_w, MAX64);
    chk("novf.dat_s", dat_s, MIN64);
    chk("novf.ovf_s", 64'(ovf_s), 64'd1);
    tick();

    // Clear without a beat, then a fresh group
    beat(64'sd100, 1'b0);
    beat(64'sd200, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    beat(64'sd9, 1'b1);
    chk_out("clr.idle", 64'sd9, 16'd1, 1'b0);
    tick();

    // Clear with a last beat, then clear while holding
    beat(64'sd50, 1'b0);
    clear = 1'b1; out_ready = 1'b0;
    beat(-64'sd4, 1'b1);
    chk_out("clr.beat", -64'sd4, 16'd1, 1'b0);
    tick();
    clear = 1'b0;
    chk_out("clr.hold", -64'sd4, 16'd1, 1'b0);
    out_ready = 1'b1;
    tick();

    // Reset mid-group and during HOLD
    beat(64'sd1, 1'b0);
    beat(64'sd2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstg.rdy", 64'(rdy_w), 64'd1);
    beat(64'sd3, 1'b1);
    chk_out("rstg", 64'sd3, 16'd1, 1'b0);
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsth.vld", 64'(vld_w), 64'd0);
    chk("rsth.rdy", 64'(rdy_w), 64'd1);

    // Random traffic against a transaction model
    m_hold = 1'b0; m_acc_w = '0; m_acc_s = '0; m_cnt = '0; m_ovf_w = 1'b0; m_ovf_s = 1'b0;
    e_w = '0; e_s = '0; e_cnt = '0; e_ovf_w = 1'b0; e_ovf_s = 1'b0;
    begin
      int nbeats;
      int cyc;
      nbeats = 0;
      cyc = 0;
      while (nbeats < 1000 && cyc < 20000) begin
        logic [63:0] d, sw, ss;
        logic        ow, os;
        cyc++;
        d = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 0) d = 64'($signed(d[15:0]));
        in_data   = d;
        in_valid  = ($urandom_range(0, 3) != 0);
        in_last   = ($urandom_range(0, 4) == 0);
        clear     = ($urandom_range(0, 19) == 0);
        out_ready = ($urandom_range(0, 1) == 0);
        #1;
        chk("rnd.rdy", 64'(rdy_w), 64'(!m_hold));
        chk("rnd.vld", 64'(vld_s), 64'(m_hold));
        if (m_hold) begin
          if (out_ready) begin
            chk("rnd.dat_w", dat_w, e_w);
            chk("rnd.dat_s", dat_s, e_s);
            chk("rnd.cnt", 64'(cnt_w), 64'(e_cnt));
            chk("rnd.ovf_w", 64'(ovf_w), 64'(e_ovf_w));
            chk("rnd.ovf_s", 64'(ovf_s), 64'(e_ovf_s));
            m_hold = 1'b0;
          end
        end else begin
          if (clear) begin
            m_acc_w = '0; m_acc_s = '0; m_cnt = '0; m_ovf_w = 1'b0; m_ovf_s = 1'b0;
          end
          if (in_valid) begin
            nbeats++;
            sw = m_acc_w + d;
            ow = (m_acc_w[63] == d[63]) && (sw[63] != d[63]);
            ss = m_acc_s + d;
            os = (m_acc_s[63] == d[63]) && (ss[63] != d[63]);
            if (os) ss = d[63] ? MIN64 : MAX64;
            m_acc_w = sw; m_acc_s = ss; m_cnt = m_cnt + 16'd1;
            m_ovf_w = m_ovf_w | ow; m_ovf_s = m_ovf_s | os;
            if (in_last) begin
              e_w = m_acc_w; e_s = m_acc_s; e_cnt = m_cnt; e_ovf_w = m_ovf_w; e_ovf_s = m_ovf_s;
              m_acc_w = '0; m_acc_s = '0; m_cnt = '0; m_ovf_w = 1'b0; m_ovf_s = 1'b0;
              m_hold = 1'b1;
            end
          end
        end
        @(posedge clk);
        #1;
      end
      chk("rnd.beats", 64'(nbeats), 64'd1000);
    end

    in_valid = 1'b0; clear = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
